muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit; sits beside the combinational ALU in the execute stage.
- Serves MIPS MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
- The datapath issues an operation through a start/busy/done handshake and reads HI/LO for MFHI/MFLO.
- MTHI/MTLO and pipeline flush (abort) are also handled here.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- op1  in  WIDTH  multiplicand / dividend (rs); sampled with start
- op2  in  WIDTH  multiplier / divisor (rt); sampled with start
- abort  in  1  flush; cancels an in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO updated this cycle
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy=0, done=0, hi=0, lo=0; internal accumulators cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op, op1, op2.
  - Signed ops (MULT, DIV) latch operand magnitudes plus a result-sign and a remainder-sign flag.
  - Iteration counter loads WIDTH; transition to CALC.
- CALC:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; at 0, go to FIX.
- FIX (1 cycle):
  - Apply sign correction: negate the 2*WIDTH product if the result sign is negative.
  - Negate the quotient if operand signs differ; negate the remainder if the dividend was negative.
  - Division truncates toward zero.
  - Write HI/LO and return to IDLE.
- Latency:
  - start accepted at edge 0.
  - busy=1 from after edge 0 through edge WIDTH+1 (33 cycles for WIDTH=32).
  - At edge WIDTH+1, hi/lo are updated, done=1 for exactly one cycle, and busy=0.
- Back-to-back: start is accepted in the same cycle done is high; busy stays 0 only for that cycle.
- start while busy: ignored, no queuing; op/op1/op2 are not re-sampled.
- Divide by zero (op2=0, DIV or DIVU):
  - Sign correction is skipped.
  - lo=all ones, hi=op1 as sampled.
  - Same latency as a normal divide; no exception raised.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0; no flag.
- MULTU/DIVU: operands are treated as unsigned; no sign fixup.
- MTHI/MTLO:
  - In IDLE with start=0: hi_we/lo_we write wdata at the edge; both may be asserted together.
  - Ignored while busy.
  - If asserted together with an accepted start, the write is discarded and start wins.
- abort:
  - In CALC or FIX: return to IDLE at the next edge; hi/lo are unchanged; no done pulse; busy=0 the following cycle.
  - In IDLE: no effect, and blocks a same-cycle start.
- hi/lo change only on reset, FIX completion, or an MTHI/MTLO write. They are stable while busy, so stale reads are permitted and it is the hazard logic's job to stall.

Test Plan:
- MULTU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> done at cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT op1=-3 (0xFFFFFFFD), op2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV -8/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF8.
- Handshake/boundaries:
  - Start DIVU 100/7; at cycle 10 pulse start with MULTU 2x2 -> ignored; result lo=14, hi=2.
  - hi_we with wdata=0xDEAD while busy -> no change.
  - Start issued in the done cycle -> accepted; second result arrives 33 cycles later.
- Abort/reset:
  - MTHI 0xAAAAAAAA and MTLO 0x55555555, then MULTU 3x3; abort at cycle 15 -> no done, busy=0 next cycle, hi/lo hold 0xAAAAAAAA/0x55555555.
  - Assert RST mid-CALC (between edges) -> busy, done, hi and lo go to 0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide on operand
// magnitudes, followed by a one-cycle sign fixup that writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;       // remaining radix-2 steps
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
  logic [WIDTH-1:0]   dvs_q, dvs_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   op1_q, op1_d;       // raw dividend, returned on divide by zero
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_q, neg_d;       // product / quotient must be negated
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand conditioning and one radix-2 step of each algorithm.
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Datapath arithmetic shared by the state machine below.
  always_comb begin
    accept   = (state_q == IDLE) && start && !abort;
    // op[0]=0 selects the signed variants (MULT, DIV).
    a_neg    = !op[0] && op1[WIDTH-1];
    b_neg    = !op[0] && op2[WIDTH-1];
    a_mag    = a_neg ? (~op1 + 1'b1) : op1;
    b_mag    = b_neg ? (~op2 + 1'b1) : op2;

    // Shift-add: the multiplier sits in the low half and is consumed LSB first.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: the dividend shifts out of the low half into the remainder.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, dvs_q};
    div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_q     ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register update logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    op1_d     = op1_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          cnt_d     = CW'(WIDTH);
          is_div_d  = op[1];
          div0_d    = op[1] && (op2 == '0);
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          op1_d     = op1;
          dvs_d     = op[1] ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end else if (!start) begin
          // MTHI/MTLO only when no start is pending this cycle.
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (div0_q) begin
            hi_d = op1_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including HI/LO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      op1_q     <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      op1_q     <= op1_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, abort, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] op1, op2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .op1(op1), .op2(op2),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion. A nonzero disturb_at
  // pulses a second start plus an MTHI write at that cycle of the busy window.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int disturb_at);
    int n;
    int nb;
    logic [31:0] hold_hi;
    hold_hi = hi;
    start = 1'b1; op = o; op1 = a; op2 = b;
    tick();
    start = 1'b0; op1 = ~a; op2 = ~b;
    check($sformatf("%s_accept", tag), {62'd0, busy, done}, 64'd2);
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 60) begin
      if (disturb_at != 0 && n == disturb_at) begin
        start = 1'b1; op = MULTU; op1 = 32'd2; op2 = 32'd2;
        hi_we = 1'b1; wdata = 32'h0000DEAD;
      end
      tick();
      n++;
      start = 1'b0; hi_we = 1'b0;
      if (!done && busy) nb++;
      if (disturb_at != 0 && n == disturb_at + 1)
        check($sformatf("%s_hi_hold", tag), {32'd0, hi}, {32'd0, hold_hi});
    end
    check($sformatf("%s_latency", tag), 64'(n), 64'd33);
    check($sformatf("%s_busy_cycles", tag), 64'(nb), 64'd33);
    check($sformatf("%s_result", tag), {hi, lo}, {exp_hi, exp_lo});
    check($sformatf("%s_busy_in_done", tag), {63'd0, busy}, 64'd0);
    if (disturb_at != 0) begin
      tick();
      check($sformatf("%s_no_queue", tag), {62'd0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    int dn;
    RST = 1'b1; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; op1 = '0; op2 = '0; wdata = '0;
    #12;
    check("reset", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    RST = 1'b0;
    tick();

    // Arithmetic vectors, issued back-to-back (each start lands in the done cycle).
    run_op("multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_neg",   MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("mult_min",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op("div_neg",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu_7_2",   DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        0);
    run_op("div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("divu_zero",  DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 0);
    run_op("div_zero",   DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 0);
    run_op("divu_busy",  DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10);

    // Abort in IDLE blocks a same-cycle start.
    start = 1'b1; abort = 1'b1; op = MULTU; op1 = 32'd3; op2 = 32'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_blocks", {62'd0, busy, done}, 64'd0);

    // MTHI then MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'hAAAAAAAA;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h55555555;
    tick();
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'hAAAAAAAA_55555555);

    // Abort mid-calculation: HI/LO hold, no done pulse ever follows.
    start = 1'b1; op = MULTU; op1 = 32'd3; op2 = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("pre_abort_busy", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {62'd0, busy, done}, 64'd0);
    check("abort_hold", {hi, lo}, 64'hAAAAAAAA_55555555);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    // Asynchronous reset between edges during CALC.
    start = 1'b1; op = MULTU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", {30'd0, busy, done, hi}, 64'd0);
    check("async_reset_lo", {32'd0, lo}, 64'd0);
    #2;
    RST = 1'b0;
    tick();
    run_op("after_reset", MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
